// File: rtl/arith_defs_pkg.sv
// ============================================================================
//  arith_defs : shared constants and state encoding for serial arithmetic units
//  Rev 1.0
// ============================================================================
`default_nettype none

package arith_defs;

   localparam int MAX_WIDTH = 32;

   // 2'd3 is never entered; the FSM decodes it back to ST_IDLE.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   function automatic int cnt_width(input int w);
      return $clog2(w) + 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/full_subtractor.sv
// ============================================================================
//  full_subtractor : one-bit combinational x - y - bi cell
//  Rev 1.0
// ============================================================================
`default_nettype none

module full_subtractor (
   input  logic x,
   input  logic y,
   input  logic bi,
   output logic d,
   output logic bo
);

   assign d  = x ^ y ^ bi;
   assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

`default_nettype wire

// File: rtl/serial_subtractor.sv
// ============================================================================
//  serial_subtractor : bit-serial A - B - BIN, LSB first, start/busy/done
//  Rev 1.0
// ============================================================================
`default_nettype none

module serial_subtractor
   import arith_defs::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf
);

   localparam int            CW   = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] r_sh;
   logic [WIDTH-1:0] r_next;
   logic             brw;
   logic [CW-1:0]    cnt;
   logic             d_bit;
   logic             bo_bit;

   full_subtractor u_fs (
      .x  (a_sh[0]),
      .y  (b_sh[0]),
      .bi (brw),
      .d  (d_bit),
      .bo (bo_bit)
   );

   // Each new difference bit enters at the MSB so the LSB lands at bit 0 after WIDTH steps.
   generate
      if (WIDTH == 1) begin : g_w1
         assign r_next = d_bit;
      end else begin : g_wn
         assign r_next = {d_bit, r_sh[WIDTH-1:1]};
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         diff  <= '0;
         bout  <= 1'b0;
         ovf   <= 1'b0;
         a_sh  <= '0;
         b_sh  <= '0;
         r_sh  <= '0;
         brw   <= 1'b0;
         cnt   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a_sh  <= a;
                  b_sh  <= b;
                  brw   <= bin;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               a_sh <= a_sh >> 1;
               b_sh <= b_sh >> 1;
               r_sh <= r_next;
               brw  <= bo_bit;
               cnt  <= cnt + 1'b1;
               if (cnt == LAST) begin
                  // On the last step a_sh[0]/b_sh[0] are the operand sign bits.
                  diff  <= r_next;
                  bout  <= bo_bit;
                  ovf   <= (a_sh[0] ^ b_sh[0]) & (d_bit ^ a_sh[0]);
                  done  <= 1'b1;
                  state <= ST_DONE;
               end
            end
            ST_DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// ============================================================================
//  tb_serial_subtractor : vector table, handshake corners and random sweep
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_serial_subtractor;

   logic       clk = 1'b0;
   logic       rst;
   logic       start8, bin8, busy8, done8, bout8, ovf8;
   logic [7:0] a8, b8, diff8;
   logic       start1, bin1, busy1, done1, bout1, ovf1;
   logic [0:0] a1, b1, diff1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
      .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .ovf(ovf8)
   );

   serial_subtractor #(.WIDTH(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .bin(bin1),
      .busy(busy1), .done(done1), .diff(diff1), .bout(bout1), .ovf(ovf1)
   );

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       bin;
      logic [7:0] diff;
      logic       bout;
      logic       ovf;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Integer reference: returns {ovf, bout, diff[7:0]} for a w-bit subtract.
   function automatic logic [9:0] model(input int w, input longint a, input longint b, input longint bi);
      longint lim, full, sa, sb, sr;
      logic [7:0] dv;
      logic bo, ov;
      lim  = longint'(1) << w;
      full = a - b - bi;
      dv   = 8'(((full % lim) + lim) % lim);
      bo   = (full < 0);
      sa   = (a >= lim / 2) ? a - lim : a;
      sb   = (b >= lim / 2) ? b - lim : b;
      sr   = sa - sb - bi;
      ov   = (sr < -(lim / 2)) || (sr > (lim / 2) - 1);
      return {ov, bo, dv};
   endfunction

   task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input logic tbin,
                       output int lat, output int bcnt, output int dcnt, output logic stable);
      logic [7:0] held;
      logic       seen;
      seen = 1'b0; lat = -1; bcnt = 0; dcnt = 0; stable = 1'b1;
      @(negedge clk);
      a8 = ta; b8 = tb; bin8 = tbin; start8 = 1'b1;
      held = diff8;
      @(negedge clk);
      start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
      for (int i = 0; i < 40; i++) begin
         if (busy8) bcnt++;
         if (done8) begin
            dcnt++;
            if (!seen) lat = i;
            seen = 1'b1;
         end else if (!seen && diff8 !== held) begin
            stable = 1'b0;
         end
         if (seen && !busy8) break;
         @(negedge clk);
      end
   endtask

   task automatic run1(input logic ta, input logic tb, input logic tbin, output int lat);
      lat = -1;
      @(negedge clk);
      a1 = ta; b1 = tb; bin1 = tbin; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (done1 && lat < 0) lat = i;
         if (lat >= 0 && !busy1) break;
         @(negedge clk);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, bcnt, dcnt, nd, sp;
      logic stable, stab, gap;
      logic [9:0] exp;
      int t_done[$];
      logic bz[35];

      vecs[0] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0};
      vecs[1] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
      vecs[2] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
      vecs[3] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
      vecs[4] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
      vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
      vecs[6] = '{8'h80, 8'h00, 1'b1, 8'h7F, 1'b0, 1'b1};
      vecs[7] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};

      rst = 1'b1;
      start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
      start1 = 1'b0; a1 = '0; b1 = '0; bin1 = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("reset_busy", busy8, 1'b0);
      chk("reset_done", done8, 1'b0);
      chk("reset_diff", diff8, 8'h00);
      chk("reset_bout", bout8, 1'b0);
      chk("reset_ovf", ovf8, 1'b0);

      for (int i = 0; i < 8; i++) begin
         run8(vecs[i].a, vecs[i].b, vecs[i].bin, lat, bcnt, dcnt, stable);
         chk($sformatf("vec%0d_latency", i), lat, 8);
         chk($sformatf("vec%0d_busy_cycles", i), bcnt, 9);
         chk($sformatf("vec%0d_done_pulses", i), dcnt, 1);
         chk($sformatf("vec%0d_diff_stable", i), stable, 1'b1);
         chk($sformatf("vec%0d_diff", i), diff8, vecs[i].diff);
         chk($sformatf("vec%0d_bout", i), bout8, vecs[i].bout);
         chk($sformatf("vec%0d_ovf", i), ovf8, vecs[i].ovf);
      end

      // start held high: only one acceptance per pass through IDLE.
      stab = 1'b1;
      @(negedge clk);
      a8 = 8'h00; b8 = 8'h00; bin8 = 1'b1; start8 = 1'b1;
      for (int i = 0; i < 35; i++) begin
         @(negedge clk);
         bz[i] = busy8;
         if (done8) begin
            t_done.push_back(i);
            if (diff8 !== 8'hFF) stab = 1'b0;
         end else if (t_done.size() > 0 && diff8 !== 8'hFF) begin
            stab = 1'b0;
         end
      end
      start8 = 1'b0;
      chk("hold_pulse_count_ge3", t_done.size() >= 3, 1'b1);
      chk("hold_diff_stable", stab, 1'b1);
      for (int k = 1; k < t_done.size(); k++) begin
         sp  = t_done[k] - t_done[k-1];
         gap = 1'b0;
         for (int j = t_done[k-1] + 1; j < t_done[k]; j++) if (!bz[j]) gap = 1'b1;
         chk($sformatf("hold_spacing%0d", k), (sp >= 9 && sp <= 10), 1'b1);
         chk($sformatf("hold_idle_gap%0d", k), gap, 1'b1);
      end
      for (int i = 0; i < 20; i++) begin
         if (!busy8) break;
         @(negedge clk);
      end
      chk("hold_returns_idle", busy8, 1'b0);

      // Reset four edges into an operation aborts it silently.
      @(negedge clk);
      a8 = 8'h05; b8 = 8'h03; bin8 = 1'b0; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", busy8, 1'b0);
      chk("abort_done", done8, 1'b0);
      chk("abort_diff", diff8, 8'h00);
      chk("abort_bout", bout8, 1'b0);
      chk("abort_ovf", ovf8, 1'b0);
      nd = 0;
      for (int i = 0; i < 12; i++) begin
         if (done8) nd++;
         @(negedge clk);
      end
      chk("abort_no_done", nd, 0);
      run8(8'h05, 8'h03, 1'b0, lat, bcnt, dcnt, stable);
      chk("after_abort_latency", lat, 8);
      chk("after_abort_diff", diff8, 8'h02);
      chk("after_abort_bout", bout8, 1'b0);

      for (int i = 0; i < 40; i++) begin
         logic [7:0] ra, rb;
         logic       rbin;
         ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
         exp = model(8, longint'(ra), longint'(rb), longint'(rbin));
         repeat ($urandom_range(0, 2)) @(negedge clk);
         run8(ra, rb, rbin, lat, bcnt, dcnt, stable);
         chk($sformatf("rnd%0d_latency", i), lat, 8);
         chk($sformatf("rnd%0d_diff a=%h b=%h bin=%b", i, ra, rb, rbin), diff8, exp[7:0]);
         chk($sformatf("rnd%0d_bout", i), bout8, exp[8]);
         chk($sformatf("rnd%0d_ovf", i), ovf8, exp[9]);
      end

      run1(1'b0, 1'b1, 1'b0, lat);
      chk("w1_latency", lat, 1);
      chk("w1_diff", diff1, 1'b1);
      chk("w1_bout", bout1, 1'b1);
      chk("w1_ovf", ovf1, 1'b1);
      for (int v = 0; v < 8; v++) begin
         logic [2:0] vv;
         vv  = 3'(v);
         exp = model(1, longint'(vv[2]), longint'(vv[1]), longint'(vv[0]));
         run1(vv[2], vv[1], vv[0], lat);
         chk($sformatf("w1_%0d_latency", v), lat, 1);
         chk($sformatf("w1_%0d_diff", v), diff1, exp[0]);
         chk($sformatf("w1_%0d_bout", v), bout1, exp[8]);
         chk($sformatf("w1_%0d_ovf", v), ovf1, exp[9]);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
